// File: rtl/taillight_input_conditioner.sv
// ---------------------------------------------------------------------------
// taillight_input_conditioner
//
// Front end for the Thunderbird tail light FSM. Each raw switch (left, right,
// hazard) is brought into the clock domain with a 2-flop synchronizer and then
// debounced: the clean level only follows the synchronized level after it has
// differed for DEBOUNCE_CYCLES consecutive edges. A free-running tick counter
// produces the one-cycle Enable strobe every TICK_DIV cycles. Its phase
// restarts whenever any clean level changes, so a new command gets a full
// blink period.
//
// Ports:
//   Clock   in   system clock, rising-edge active
//   ResetN  in   asynchronous active-low reset
//   RawL    in   left-turn switch, asynchronous, may bounce
//   RawR    in   right-turn switch, asynchronous, may bounce
//   RawH    in   hazard switch, asynchronous, may bounce
//   Enable  out  registered one-cycle strobe (FSM state-advance enable)
//   L,R,H   out  registered clean switch levels
// ---------------------------------------------------------------------------
module taillight_input_conditioner #(
   parameter int TICK_DIV        = 12_500_000,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic Clock,
   input  logic ResetN,
   input  logic RawL,
   input  logic RawR,
   input  logic RawH,
   output logic Enable,
   output logic L,
   output logic R,
   output logic H
);

   // Counter widths; a single-cycle debounce still needs a 1-bit register.
   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TKW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TKW-1:0] TICK_LAST = TKW'(TICK_DIV - 1);

   logic [2:0] raw;
   logic [2:0] clean_q;   // current clean levels, bit 0 = L, 1 = R, 2 = H
   logic [2:0] clean_d;   // clean levels after this edge

   assign raw = {RawH, RawR, RawL};

   // -----------------------------------------------------------------------
   // Three independent synchronize + debounce channels.
   // -----------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : gen_ch
         logic           s1_q;
         logic           s2_q;
         logic           ch_clean_q;
         logic           ch_clean_d;
         logic [DBW-1:0] cnt_q;
         logic [DBW-1:0] cnt_d;

         // Any sample matching the clean level clears the count, so a
         // bouncing input restarts timing from its last transition.
         always_comb begin
            ch_clean_d = ch_clean_q;
            cnt_d      = cnt_q;
            if (s2_q == ch_clean_q) begin
               cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
               ch_clean_d = s2_q;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge Clock or negedge ResetN) begin
            if (!ResetN) begin
               s1_q       <= 1'b0;
               s2_q       <= 1'b0;
               ch_clean_q <= 1'b0;
               cnt_q      <= '0;
            end else begin
               s1_q       <= raw[gi];
               s2_q       <= s1_q;
               ch_clean_q <= ch_clean_d;
               cnt_q      <= cnt_d;
            end
         end

         assign clean_q[gi] = ch_clean_q;
         assign clean_d[gi] = ch_clean_d;
      end
   endgenerate

   // -----------------------------------------------------------------------
   // Enable tick generator.
   // -----------------------------------------------------------------------
   logic           restart;
   logic [TKW-1:0] tick_count_q;
   logic [TKW-1:0] tick_count_d;
   logic           enable_q;
   logic           enable_d;

   // Looking at next-state lets all channels changing on one edge collapse
   // into a single restart, and a restart on the wrap edge suppresses the
   // strobe.
   assign restart = |(clean_d ^ clean_q);

   always_comb begin
      tick_count_d = tick_count_q;
      enable_d     = 1'b0;
      if (restart) begin
         tick_count_d = '0;
      end else if (tick_count_q == TICK_LAST) begin
         tick_count_d = '0;
         enable_d     = 1'b1;
      end else begin
         tick_count_d = tick_count_q + 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         tick_count_q <= '0;
         enable_q     <= 1'b0;
      end else begin
         tick_count_q <= tick_count_d;
         enable_q     <= enable_d;
      end
   end

   assign Enable = enable_q;
   assign L      = clean_q[0];
   assign R      = clean_q[1];
   assign H      = clean_q[2];

endmodule

// File: tb/tb_taillight_input_conditioner.sv
// ---------------------------------------------------------------------------
// Directed bench for taillight_input_conditioner with TICK_DIV=4 and
// DEBOUNCE_CYCLES=3. Edges are numbered from the first rising edge after
// reset release (edge 1). Inputs change and outputs are sampled 1 ns after
// each rising edge, so a change made after edge n is first sampled at n+1.
// Expected Enable: high on edges that are a positive multiple of 4 after the
// most recent clean change (or after release), low otherwise.
// ---------------------------------------------------------------------------
module tb_taillight_input_conditioner;

   logic Clock;
   logic ResetN;
   logic RawL;
   logic RawR;
   logic RawH;
   logic Enable;
   logic L;
   logic R;
   logic H;

   int checks   = 0;
   int failures = 0;
   int ecnt     = 0;   // edge number since reset release
   int ref_e    = 0;   // edge of last clean change (0 = release)

   taillight_input_conditioner #(
      .TICK_DIV        (4),
      .DEBOUNCE_CYCLES (3)
   ) dut (
      .Clock  (Clock),
      .ResetN (ResetN),
      .RawL   (RawL),
      .RawR   (RawR),
      .RawH   (RawH),
      .Enable (Enable),
      .L      (L),
      .R      (R),
      .H      (H)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic exp_en(input int e, input int r);
      return (e != r) && (((e - r) % 4) == 0);
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
      ecnt++;
   endtask

   task automatic test_reset_idle();
      ResetN = 1'b0;
      RawL   = 1'b0;
      RawR   = 1'b0;
      RawH   = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      checks++;
      if ({L, R, H, Enable} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0000", {L, R, H, Enable});
      end
      checks++;
      if (dut.tick_count_q !== 2'd0) begin
         failures++;
         $display("FAIL reset_tick got=%0d exp=0", dut.tick_count_q);
      end
      ResetN = 1'b1;
      ecnt   = 0;
      ref_e  = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (Enable !== exp_en(ecnt, ref_e)) begin
            failures++;
            $display("FAIL idle_enable edge=%0d got=%b exp=%b", ecnt, Enable, exp_en(ecnt, ref_e));
         end
         checks++;
         if ({L, R, H} !== 3'b000) begin
            failures++;
            $display("FAIL idle_lrh edge=%0d got=%b exp=000", ecnt, {L, R, H});
         end
      end
      $display("test_reset_idle done at edge %0d", ecnt);
   endtask

   // RawL first sampled at edge 13 -> L rises at 17.
   task automatic test_left();
      RawL = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (ecnt == 17) ref_e = 17;
         checks++;
         if (L !== (ecnt >= 17)) begin
            failures++;
            $display("FAIL left_L edge=%0d got=%b exp=%b", ecnt, L, (ecnt >= 17));
         end
         checks++;
         if (Enable !== exp_en(ecnt, ref_e)) begin
            failures++;
            $display("FAIL left_enable edge=%0d got=%b exp=%b", ecnt, Enable, exp_en(ecnt, ref_e));
         end
      end
      $display("test_left done at edge %0d", ecnt);
   endtask

   // RawR high for samples 26,27 only: rejected.
   task automatic test_glitch_short();
      RawR = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) RawR = 1'b0;
         tick();
         checks++;
         if (R !== 1'b0) begin
            failures++;
            $display("FAIL glitch2_R edge=%0d got=%b exp=0", ecnt, R);
         end
         checks++;
         if (Enable !== exp_en(ecnt, ref_e)) begin
            failures++;
            $display("FAIL glitch2_enable edge=%0d got=%b exp=%b", ecnt, Enable, exp_en(ecnt, ref_e));
         end
      end
      $display("test_glitch_short done at edge %0d", ecnt);
   endtask

   // RawR high for samples 34..36: R rises at 38, low first sampled 37 -> falls at 41.
   task automatic test_glitch_exact();
      RawR = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i == 3) RawR = 1'b0;
         tick();
         if (ecnt == 38 || ecnt == 41) ref_e = ecnt;
         checks++;
         if (R !== (ecnt >= 38 && ecnt < 41)) begin
            failures++;
            $display("FAIL glitch3_R edge=%0d got=%b exp=%b", ecnt, R, (ecnt >= 38 && ecnt < 41));
         end
         checks++;
         if (Enable !== exp_en(ecnt, ref_e)) begin
            failures++;
            $display("FAIL glitch3_enable edge=%0d got=%b exp=%b", ecnt, Enable, exp_en(ecnt, ref_e));
         end
      end
      $display("test_glitch_exact done at edge %0d", ecnt);
   endtask

   // RawH toggles on samples 50..59, holds 1 from j=60 -> H rises at 64.
   task automatic test_bounce();
      for (int i = 0; i < 18; i++) begin
         if (i < 10) RawH = ((i % 2) == 0);
         else        RawH = 1'b1;
         tick();
         if (ecnt == 64) ref_e = 64;
         checks++;
         if (H !== (ecnt >= 64)) begin
            failures++;
            $display("FAIL bounce_H edge=%0d got=%b exp=%b", ecnt, H, (ecnt >= 64));
         end
         checks++;
         if (Enable !== exp_en(ecnt, ref_e)) begin
            failures++;
            $display("FAIL bounce_enable edge=%0d got=%b exp=%b", ecnt, Enable, exp_en(ecnt, ref_e));
         end
      end
      $display("test_bounce done at edge %0d", ecnt);
   endtask

   // RawL low first sampled at 68 -> L falls at 72, the edge where the
   // tick counter would wrap (it reads 3 after edge 71).
   task automatic test_collision();
      RawL = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (ecnt == 72) ref_e = 72;
         if (ecnt == 71) begin
            checks++;
            if (dut.tick_count_q !== 2'd3) begin
               failures++;
               $display("FAIL collision_align edge=%0d got=%0d exp=3", ecnt, dut.tick_count_q);
            end
         end
         checks++;
         if (L !== (ecnt < 72)) begin
            failures++;
            $display("FAIL collision_L edge=%0d got=%b exp=%b", ecnt, L, (ecnt < 72));
         end
         checks++;
         if (Enable !== exp_en(ecnt, ref_e)) begin
            failures++;
            $display("FAIL collision_enable edge=%0d got=%b exp=%b", ecnt, Enable, exp_en(ecnt, ref_e));
         end
      end
      $display("test_collision done at edge %0d", ecnt);
   endtask

   // L rises at 81, tick counter reaches 2 at 83, then reset between edges.
   task automatic test_async_reset();
      RawL = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (ecnt == 81) ref_e = 81;
         checks++;
         if (L !== (ecnt >= 81)) begin
            failures++;
            $display("FAIL pre_reset_L edge=%0d got=%b exp=%b", ecnt, L, (ecnt >= 81));
         end
      end
      checks++;
      if (dut.tick_count_q !== 2'd2) begin
         failures++;
         $display("FAIL pre_reset_tick got=%0d exp=2", dut.tick_count_q);
      end
      #2;
      ResetN = 1'b0;
      #1;
      checks++;
      if ({L, R, H, Enable} !== 4'b0000) begin
         failures++;
         $display("FAIL async_outputs got=%b exp=0000", {L, R, H, Enable});
      end
      checks++;
      if (dut.tick_count_q !== 2'd0) begin
         failures++;
         $display("FAIL async_tick got=%0d exp=0", dut.tick_count_q);
      end
      @(posedge Clock);
      #1;
      checks++;
      if ({L, R, H, Enable} !== 4'b0000) begin
         failures++;
         $display("FAIL held_reset got=%b exp=0000", {L, R, H, Enable});
      end
      // RawL and RawH still 1: both are first sampled at edge 1 and update
      // together at edge 5 with a single restart.
      ResetN = 1'b1;
      ecnt   = 0;
      ref_e  = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (ecnt == 5) ref_e = 5;
         checks++;
         if ({L, R, H} !== {(ecnt >= 5), 1'b0, (ecnt >= 5)}) begin
            failures++;
            $display("FAIL post_reset_lrh edge=%0d got=%b exp=%b", ecnt, {L, R, H}, {(ecnt >= 5), 1'b0, (ecnt >= 5)});
         end
         checks++;
         if (Enable !== exp_en(ecnt, ref_e)) begin
            failures++;
            $display("FAIL post_reset_enable edge=%0d got=%b exp=%b", ecnt, Enable, exp_en(ecnt, ref_e));
         end
      end
      $display("test_async_reset done at edge %0d", ecnt);
   endtask

   initial begin
      test_reset_idle();
      test_left();
      test_glitch_short();
      test_glitch_exact();
      test_bounce();
      test_collision();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
